nn_frame_loader: RTL and testbench
==================================

// Module: nn_frame_loader
// PURPOSE
//   Producer side of the neural_network image interface. Accepts a 28x28 8-bit pixel stream over a valid/ready handshake and fills the img[0:783] buffer.
//   Starts the network with a reset pulse followed by enable, captures digit_out on NN_done and returns it over a valid/ready result handshake.
//   Sits between the host/DMA pixel source and neural_network.
// PARAMETERS
//   IMG_W    28      pixels per row
//   IMG_H    28      rows per frame; NPIX = IMG_W*IMG_H = 784
//   PIX_W    8       pixel width and digit width
//   TIMEOUT  65535   max cycles waiting for nn_done before forcing a result
// PORTS
//   clk          in   1          single clock, all logic on posedge
//   reset        in   1          synchronous, active-high
//   pix_valid    in   1          pixel stream valid
//   pix_ready    out  1          pixel stream ready
//   pix_data     in   PIX_W      pixel value, row-major, pixel 0 first
//   pix_last     in   1          marks final pixel of frame
//   img_out      out  PIX_W x NPIX  unpacked [0:783] image buffer -> neural_network img
//   nn_reset     out  1          reset to neural_network
//   nn_enable    out  1          enable to neural_network
//   nn_done      in   1          NN_done from neural_network
//   nn_digit     in   PIX_W      digit_out from neural_network
//   res_valid    out  1          result valid
//   res_ready    in   1          result ready
//   res_digit    out  PIX_W      classified digit (0..9), 8'hFF on timeout
//   res_timeout  out  1          qualifies res_digit: run timed out
//   frame_err    out  1          one-cycle pulse: pix_last misaligned
//   frame_cnt    out  16         completed runs, wraps at 16'hFFFF -> 0
// BEHAVIOUR
//   Reset values: pix_ready=0, nn_enable=0, res_valid=0, res_digit=0, res_timeout=0, frame_err=0, frame_cnt=0, state=LOAD, wr_addr=0.
//     img_out is not cleared.
//   nn_reset = reset | run_start_pulse (combinational OR); the network is reset whenever this block is.
//   FSM: LOAD -> START -> RUN -> RESULT -> LOAD.
//   LOAD: pix_ready=1 (registered, first high the cycle after reset deasserts).
//     Beat = pix_valid & pix_ready -> img_out[wr_addr] <= pix_data; wr_addr++.
//     Beat with wr_addr==NPIX-1: frame complete, go to START, pix_ready=0 next cycle.
//       If pix_last=0 on that beat, frame_err pulses and the frame is still used.
//     Beat with pix_last=1 and wr_addr<NPIX-1: pixel dropped, frame_err pulses, wr_addr<=0, stay in LOAD (short frame discarded).
//   START: exactly 1 cycle. nn_reset=1, nn_enable=0; clears timeout counter.
//   RUN: nn_enable=1; img_out held stable; timeout counter increments each cycle.
//     nn_done=1 sampled -> res_digit<=nn_digit, res_timeout<=0.
//     counter==TIMEOUT-1 with no nn_done -> res_digit<=8'hFF, res_timeout<=1.
//     Either case: res_valid=1, nn_enable=0 next cycle, frame_cnt++, go to RESULT.
//     nn_done wins over timeout when both occur in the same cycle.
//   RESULT: res_valid and res_digit held until res_valid & res_ready.
//     Next cycle: res_valid=0, wr_addr=0, state LOAD, pix_ready=1.
//     res_ready is ignored outside RESULT.
//   Latency: last pixel beat at cycle N -> nn_reset high at N+1 -> nn_enable high at N+2. nn_done high at M -> res_valid high at M+1.
//   Reset in any state: returns to LOAD immediately; partial frame and pending result discarded; nn_reset high for the whole reset.
//   pix_valid while pix_ready=0: ignored; the source must hold the data.
// TESTING
//   1. Reset, stream 784 pixels (value = addr[7:0]) with pix_last on #783, NN model returns 7 after 50 cycles ->
//      img_out[i]=i[7:0]; nn_reset 1 cycle at N+1; nn_enable at N+2; res_valid, res_digit=7, frame_cnt=1.
//   2. Random pix_valid gaps and res_ready held low 20 cycles ->
//      no pixel lost or duplicated; res_digit stable until handshake; pix_ready=1 the cycle after the handshake.
//   3. pix_last on pixel #100 ->
//      frame_err pulse, no nn_reset; the next full 784-pixel frame loads from img_out[0].
//   4. 784th pixel without pix_last ->
//      frame_err pulse and the run still starts; with TIMEOUT=16 and nn_done never asserted: res_valid at START+17, res_digit=8'hFF, res_timeout=1.
//   5. reset asserted mid-RUN ->
//      nn_enable=0, nn_reset=1 during reset, res_valid=0, frame_cnt unchanged, pix_ready=1 one cycle after reset drops.
//   6. nn_done and timeout in the same cycle -> res_timeout=0, res_digit=nn_digit.

Source files
------------

// File: rtl/nn_frame_loader.sv
// Pixel-stream front end for neural_network: fills the image buffer, pulses the
// network reset, runs it with a timeout and returns the digit on a valid/ready port.
module nn_frame_loader #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int PIX_W   = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_last,
  output logic [PIX_W-1:0] img_out [0:IMG_W*IMG_H-1],
  output logic             nn_reset,
  output logic             nn_enable,
  input  logic             nn_done,
  input  logic [PIX_W-1:0] nn_digit,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [PIX_W-1:0] res_digit,
  output logic             res_timeout,
  output logic             frame_err,
  output logic [15:0]      frame_cnt
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(NPIX);
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    RUN    = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t           state_r, state_next_s;
  logic [AW-1:0]    wr_addr_r;
  logic [CW-1:0]    tmo_cnt_r;
  logic             pix_ready_r, nn_enable_r, res_valid_r, res_timeout_r, frame_err_r;
  logic [PIX_W-1:0] res_digit_r;
  logic [15:0]      frame_cnt_r;
  logic             beat_s, frame_full_s, short_s, misalign_s, run_end_s, handshake_s;

  always_comb begin
    beat_s       = pix_valid & pix_ready_r & (state_r == LOAD);
    frame_full_s = beat_s & (wr_addr_r == LAST_ADDR);
    short_s      = beat_s & pix_last & (wr_addr_r != LAST_ADDR);
    misalign_s   = short_s | (frame_full_s & ~pix_last);
    run_end_s    = (state_r == RUN) & (nn_done | (tmo_cnt_r == TO_LAST));
    handshake_s  = (state_r == RESULT) & res_valid_r & res_ready;
  end

  always_comb begin
    state_next_s = state_r;
    case (state_r)
      LOAD: begin
        if (frame_full_s) state_next_s = START;
        else              state_next_s = LOAD;
      end
      START: state_next_s = RUN;
      RUN: begin
        if (run_end_s) state_next_s = RESULT;
        else           state_next_s = RUN;
      end
      RESULT: begin
        if (handshake_s) state_next_s = LOAD;
        else             state_next_s = RESULT;
      end
      default: state_next_s = LOAD;
    endcase
  end

  // Handshake flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= LOAD;
      wr_addr_r     <= '0;
      tmo_cnt_r     <= '0;
      pix_ready_r   <= 1'b0;
      nn_enable_r   <= 1'b0;
      res_valid_r   <= 1'b0;
      res_digit_r   <= '0;
      res_timeout_r <= 1'b0;
      frame_err_r   <= 1'b0;
      frame_cnt_r   <= 16'd0;
    end else begin
      state_r     <= state_next_s;
      pix_ready_r <= (state_next_s == LOAD);
      nn_enable_r <= (state_next_s == RUN);
      frame_err_r <= misalign_s;

      if (frame_full_s | short_s | handshake_s) wr_addr_r <= '0;
      else if (beat_s)                          wr_addr_r <= wr_addr_r + AW'(1);
      else                                      wr_addr_r <= wr_addr_r;

      if (state_r == START)    tmo_cnt_r <= '0;
      else if (state_r == RUN) tmo_cnt_r <= tmo_cnt_r + CW'(1);
      else                     tmo_cnt_r <= tmo_cnt_r;

      // A done in the final timeout cycle still delivers the real digit.
      if (run_end_s) begin
        res_valid_r   <= 1'b1;
        res_digit_r   <= nn_done ? nn_digit : {PIX_W{1'b1}};
        res_timeout_r <= ~nn_done;
        frame_cnt_r   <= frame_cnt_r + 16'd1;
      end else if (handshake_s) begin
        res_valid_r   <= 1'b0;
      end
    end
  end

  // Image store has no reset; short-frame terminators are never written.
  always_ff @(posedge clk) begin
    if (beat_s & ~short_s) img_out[wr_addr_r] <= pix_data;
  end

  assign nn_reset    = reset | (state_r == START);
  assign pix_ready   = pix_ready_r;
  assign nn_enable   = nn_enable_r;
  assign res_valid   = res_valid_r;
  assign res_digit   = res_digit_r;
  assign res_timeout = res_timeout_r;
  assign frame_err   = frame_err_r;
  assign frame_cnt   = frame_cnt_r;
endmodule

// File: tb/tb_nn_frame_loader.sv
// Bench for nn_frame_loader: table of frame scenarios plus random frames, checked
// against an image/result model derived from the loader's frame and run rules.
module tb_nn_frame_loader;
  localparam int NPIX = 784;
  localparam int TMO  = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_valid = 1'b0, pix_last = 1'b0, nn_done = 1'b0, res_ready = 1'b0;
  logic [7:0] pix_data = 8'd0, nn_digit = 8'd0;
  logic       pix_ready, nn_reset, nn_enable, res_valid, res_timeout, frame_err;
  logic [7:0] res_digit;
  logic [15:0] frame_cnt;
  logic [7:0] img_out [0:NPIX-1];

  always #5 clk = ~clk;

  nn_frame_loader #(.IMG_W(28), .IMG_H(28), .PIX_W(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_last(pix_last), .img_out(img_out),
    .nn_reset(nn_reset), .nn_enable(nn_enable), .nn_done(nn_done), .nn_digit(nn_digit),
    .res_valid(res_valid), .res_ready(res_ready), .res_digit(res_digit),
    .res_timeout(res_timeout), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0]  exp_img [0:NPIX-1];
  logic [7:0]  vals [0:NPIX-1];
  logic [15:0] exp_cnt = 16'd0;

  typedef struct {
    int         npix;
    bit         last_ok;
    int         gap;
    bit         ramp;
    int         delay;
    logic [7:0] digit;
    int         hold;
    int         exp_err;
    bit         exp_run;
  } vec_t;
  vec_t vecs [0:6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    int bad = 0;
    reset = 1'b1;
    pix_valid = 1'b1;
    pix_data = 8'($urandom);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (nn_reset !== 1'b1 || nn_enable !== 1'b0 || res_valid !== 1'b0 || pix_ready !== 1'b0 ||
          frame_err !== 1'b0 || res_timeout !== 1'b0 || res_digit !== 8'd0 || frame_cnt !== 16'd0)
        bad++;
    end
    chk("reset_values", bad, 0);
    reset = 1'b0;
    pix_valid = 1'b0;
    exp_cnt = 16'd0;
    @(negedge clk);
    chk("post_reset_pix_ready", pix_ready, 1);
    chk("post_reset_nn_reset", nn_reset, 0);
    chk("post_reset_res_valid", res_valid, 0);
  endtask

  // Streams npix pixels; pix_last on the final one only when last_ok is set.
  task automatic stream(input int npix, input bit last_ok, input int gap, input bit ramp,
                        output int errs_seen);
    int idx = 0;
    int budget = 0;
    bit rdy;
    errs_seen = 0;
    for (int i = 0; i < npix; i++) vals[i] = ramp ? i[7:0] : 8'($urandom);
    while (idx < npix && budget < npix * 8 + 200) begin
      rdy       = pix_ready;
      pix_valid = ($urandom_range(99) >= gap);
      pix_data  = vals[idx];
      pix_last  = (idx == npix - 1) ? last_ok : 1'b0;
      res_ready = 1'($urandom_range(1));
      @(negedge clk);
      budget++;
      if (frame_err === 1'b1) errs_seen++;
      if (pix_valid && rdy) begin
        if (!(pix_last && idx < NPIX - 1)) exp_img[idx] = vals[idx];
        idx++;
      end
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    res_ready = 1'b0;
    chk("stream_complete", idx, npix);
  endtask

  // Called on the cycle after the final beat; models the network and the result port.
  task automatic run_nn(input int delay, input logic [7:0] digit, input int hold);
    int r = 0;
    int bad = 0;
    int stable_bad = 0;
    bit exp_to;
    int exp_r;
    logic [7:0] exp_digit;
    chk("start_nn_reset", nn_reset, 1);
    chk("start_nn_enable", nn_enable, 0);
    chk("start_pix_ready", pix_ready, 0);
    pix_valid = 1'b1;
    pix_data  = 8'($urandom);
    @(negedge clk);
    chk("run_nn_reset", nn_reset, 0);
    chk("run_nn_enable", nn_enable, 1);
    exp_to    = (delay > TMO - 1);
    exp_r     = exp_to ? TMO : delay + 1;
    exp_digit = exp_to ? 8'hFF : digit;
    while (res_valid !== 1'b1 && r < TMO + 10) begin
      nn_done  = (r == delay);
      nn_digit = (r == delay) ? digit : 8'($urandom);
      pix_data = 8'($urandom);
      @(negedge clk);
      r++;
      nn_done = 1'b0;
    end
    exp_cnt++;
    chk("result_latency", r, exp_r);
    chk("res_valid", res_valid, 1);
    chk("res_digit", res_digit, exp_digit);
    chk("res_timeout", res_timeout, exp_to);
    chk("result_nn_enable", nn_enable, 0);
    chk("frame_cnt", frame_cnt, exp_cnt);
    for (int i = 0; i < NPIX; i++) if (img_out[i] !== exp_img[i]) bad++;
    chk("img_contents", bad, 0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_digit !== exp_digit || res_timeout !== exp_to) stable_bad++;
    end
    chk("result_stable", stable_bad, 0);
    res_ready = 1'b1;
    pix_valid = 1'b0;
    @(negedge clk);
    res_ready = 1'b0;
    chk("after_hs_res_valid", res_valid, 0);
    chk("after_hs_pix_ready", pix_ready, 1);
  endtask

  task automatic apply(input vec_t v);
    int errs;
    stream(v.npix, v.last_ok, v.gap, v.ramp, errs);
    chk("frame_err_count", errs, v.exp_err);
    if (v.exp_run) begin
      run_nn(v.delay, v.digit, v.hold);
    end else begin
      chk("short_no_nn_reset", nn_reset, 0);
      chk("short_pix_ready", pix_ready, 1);
      chk("short_frame_cnt", frame_cnt, exp_cnt);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    vec_t rv;
    //        npix  last gap ramp delay    digit hold err run
    vecs[0] = '{NPIX, 1'b1,  0, 1'b1, 50,      8'd7, 0,  0, 1'b1};
    vecs[1] = '{NPIX, 1'b1, 40, 1'b0, 10,      8'd3, 20, 0, 1'b1};
    vecs[2] = '{101,  1'b1,  0, 1'b0, 0,       8'd0, 0,  1, 1'b0};
    vecs[3] = '{NPIX, 1'b0, 10, 1'b0, 1000,    8'd4, 2,  1, 1'b1};
    vecs[4] = '{NPIX, 1'b1,  0, 1'b0, TMO - 1, 8'd5, 1,  0, 1'b1};
    vecs[5] = '{NPIX, 1'b1, 25, 1'b0, 0,       8'd9, 3,  0, 1'b1};
    vecs[6] = '{NPIX, 1'b1,  5, 1'b0, TMO - 2, 8'd2, 0,  0, 1'b1};

    do_reset();
    for (int v = 0; v < 7; v++) apply(vecs[v]);

    for (int n = 0; n < 5; n++) begin
      rv.npix    = ($urandom_range(2) == 0) ? $urandom_range(1, NPIX - 1) : NPIX;
      rv.last_ok = (rv.npix < NPIX) ? 1'b1 : 1'($urandom_range(1));
      rv.gap     = $urandom_range(50);
      rv.ramp    = 1'b0;
      rv.delay   = $urandom_range(TMO + 5);
      rv.digit   = 8'($urandom_range(9));
      rv.hold    = $urandom_range(5);
      rv.exp_err = (rv.npix < NPIX || !rv.last_ok) ? 1 : 0;
      rv.exp_run = (rv.npix == NPIX);
      apply(rv);
    end

    // Reset in the middle of a run: the aborted run must not count.
    stream(NPIX, 1'b1, 0, 1'b0, errs);
    chk("midrun_frame_err", errs, 0);
    @(negedge clk);
    for (int k = 0; k < 10; k++) @(negedge clk);
    chk("midrun_nn_enable", nn_enable, 1);
    chk("midrun_res_valid", res_valid, 0);
    chk("midrun_frame_cnt", frame_cnt, exp_cnt);
    do_reset();

    // Reset in the middle of a frame: the partial frame is discarded.
    stream(300, 1'b0, 0, 1'b0, errs);
    chk("partial_frame_err", errs, 0);
    chk("partial_nn_reset", nn_reset, 0);
    do_reset();
    stream(NPIX, 1'b1, 15, 1'b0, errs);
    chk("post_reset_frame_err", errs, 0);
    run_nn(20, 8'd6, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
